// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-domain pointer, level and flag controller for dual-clock FIFOs
module fifo_wr_ctrl #(
  parameter int AW   = 2,
  parameter int SYNC = 2
) (
  input  logic          reset,
  input  logic          wr_clk,
  input  logic [AW:0]   wr_rd_gray_pointer,
  input  logic          wr_write,
  input  logic [AW:0]   wr_afull_thresh,
  input  logic          wr_clr_ovf,
  output logic          wr_fifo_full,
  output logic          wr_fifo_afull,
  output logic [AW:0]   wr_level,
  output logic [AW-1:0] wr_addr,
  output logic          wr_en_mem,
  output logic [AW:0]   wr_gray_pointer,
  output logic          wr_overflow
);

  // Level value that means every RAM entry is occupied.
  localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};

  logic [SYNC-1:0][AW:0] sync_q;
  logic [AW:0]           rd_gray_s;
  logic [AW:0]           rd_bin_s;
  logic [AW:0]           bin_ptr;
  logic [AW:0]           bin_next;
  logic [AW:0]           gray_next;
  logic [AW:0]           level_next;
  logic                  push;

  // Read-domain Gray pointer crosses through a plain flop chain; only one bit
  // changes per read, so any sampled value is a valid (possibly old) pointer.
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], wr_rd_gray_pointer};
    end
  end

  assign rd_gray_s = sync_q[SYNC-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin_s = '0;
    for (int i = 0; i <= AW; i++) begin
      rd_bin_s[i] = ^(rd_gray_s >> i);
    end
  end

  assign push       = wr_write & ~wr_fifo_full;
  assign wr_en_mem  = push;
  assign bin_next   = bin_ptr + {{AW{1'b0}}, push};
  assign gray_next  = bin_next ^ (bin_next >> 1);
  // Modulo subtraction; the extra pointer bit keeps full (2^AW) distinct from empty.
  assign level_next = bin_next - rd_bin_s;
  assign wr_addr    = bin_ptr[AW-1:0];

  // Pointers, level and full/almost-full all register from the same next values.
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      bin_ptr         <= '0;
      wr_gray_pointer <= '0;
      wr_level        <= '0;
      wr_fifo_full    <= 1'b0;
      wr_fifo_afull   <= 1'b0;
    end else begin
      bin_ptr         <= bin_next;
      wr_gray_pointer <= gray_next;
      wr_level        <= level_next;
      wr_fifo_full    <= (level_next == FULL_LEVEL);
      wr_fifo_afull   <= (level_next >= wr_afull_thresh);
    end
  end

  // Sticky overflow; a new rejected write beats a simultaneous clear.
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      wr_overflow <= 1'b0;
    end else if (wr_write & wr_fifo_full) begin
      wr_overflow <= 1'b1;
    end else if (wr_clr_ovf) begin
      wr_overflow <= 1'b0;
    end
  end

endmodule
